// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// flush and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int DW = 72,
    parameter int IW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [IW-1:0] in_inst,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_inst,
    output logic [CW-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          out_valid_reg, out_valid_next;
    logic [DW-1:0] main_data_reg, main_data_next;
    logic [IW-1:0] main_inst_reg, main_inst_next;
    logic [DW-1:0] skid_data_reg, skid_data_next;
    logic [IW-1:0] skid_inst_reg, skid_inst_next;
    logic [CW-1:0] bubble_reg, bubble_next;

    logic accept;
    logic fire;

    assign in_ready   = (state_reg != FULL);
    assign out_valid  = out_valid_reg;
    assign out_data   = main_data_reg;
    assign out_inst   = main_inst_reg;
    assign bubble_cnt = bubble_reg;

    assign accept = in_valid & in_ready;
    assign fire   = out_valid_reg & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            main_data_reg <= '0;
            main_inst_reg <= '0;
            skid_data_reg <= '0;
            skid_inst_reg <= '0;
            bubble_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            main_data_reg <= main_data_next;
            main_inst_reg <= main_inst_next;
            skid_data_reg <= skid_data_next;
            skid_inst_reg <= skid_inst_next;
            bubble_reg    <= bubble_next;
        end
    end

    // main_inst is never cleared on drain or flush so the last tag stays visible.
    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        main_inst_next = main_inst_reg;
        skid_data_next = skid_data_reg;
        skid_inst_next = skid_inst_reg;

        if (flush) begin
            state_next     = EMPTY;
            main_data_next = '0;
            skid_data_next = '0;
            skid_inst_next = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next     = ONE;
                        main_data_next = in_data;
                        main_inst_next = in_inst;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_data_next = in_data;
                        main_inst_next = in_inst;
                    end else if (accept) begin
                        state_next     = FULL;
                        skid_data_next = in_data;
                        skid_inst_next = in_inst;
                    end else if (fire) begin
                        state_next     = EMPTY;
                        main_data_next = '0;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_next     = ONE;
                        main_data_next = skid_data_reg;
                        main_inst_next = skid_inst_reg;
                        skid_data_next = '0;
                        skid_inst_next = '0;
                    end
                end
                default: begin
                    state_next     = EMPTY;
                    main_data_next = '0;
                    skid_data_next = '0;
                    skid_inst_next = '0;
                end
            endcase
        end
    end

    assign out_valid_next = (state_next != EMPTY);

    // Saturating count of edges where downstream was ready but idle.
    always_comb begin
        bubble_next = bubble_reg;
        if (out_ready && !out_valid_reg && (bubble_reg != {CW{1'b1}}))
            bubble_next = bubble_reg + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, flush,
// bubble saturation and asynchronous reset.
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_inst;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_inst;
    logic [CW-1:0] bubble_cnt;

    int total;
    int bad;

    pipe_stage_reg #(.DW(DW), .IW(IW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_inst   (out_inst),
        .bubble_cnt (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DW-1:0] d, input logic [IW-1:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_inst  = t;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inst   = '0;
        out_ready = 1'b0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_inst", 32'(out_inst), 32'd0);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        tick();
        rst = 1'b0;

        // Streaming: first accept with out_ready low, then full rate.
        offer(16'd1, 8'h11);
        tick();
        chk("stream_d1", 32'(out_data), 32'd1);
        chk("stream_v1", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            offer(16'(i), 8'(8'h10 + i));
            chk($sformatf("stream_rdy%0d", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("stream_d%0d", i), 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_v", 32'(out_valid), 32'd0);
        chk("stream_drain_d", 32'(out_data), 32'd0);
        chk("stream_drain_inst", 32'(out_inst), 32'h14);
        chk("stream_bubble", 32'(bubble_cnt), 32'd0);
        out_ready = 1'b0;

        // Backpressure: A into main, B into skid, C held upstream.
        offer(16'hA, 8'hAA);
        tick();
        chk("bp_rdy_after_a", 32'(in_ready), 32'd1);
        offer(16'hB, 8'hBB);
        tick();
        chk("bp_rdy_after_b", 32'(in_ready), 32'd0);
        chk("bp_main_a", 32'(out_data), 32'hA);
        offer(16'hC, 8'hCC);
        tick();
        chk("bp_hold_a", 32'(out_data), 32'hA);
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", 32'(out_data), 32'hB);
        chk("bp_inst_b", 32'(out_inst), 32'hBB);
        chk("bp_rdy_again", 32'(in_ready), 32'd1);
        tick();
        chk("bp_out_c", 32'(out_data), 32'hC);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_v", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Flush while FULL, with an offered entry on the same edge.
        offer(16'h1, 8'h01);
        tick();
        offer(16'h2, 8'h02);
        tick();
        chk("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        offer(16'hD, 8'hDD);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("fl_v", 32'(out_valid), 32'd0);
        chk("fl_d", 32'(out_data), 32'd0);
        chk("fl_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("fl_no_d_v", 32'(out_valid), 32'd0);
        chk("fl_no_d_d", 32'(out_data), 32'd0);
        chk("fl_bubble_zero", 32'(bubble_cnt), 32'd0);

        // Bubble counter saturation.
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 3)  chk("bub_3", 32'(bubble_cnt), 32'd3);
            if (i == 15) chk("bub_15", 32'(bubble_cnt), 32'd15);
        end
        chk("bub_sat", 32'(bubble_cnt), 32'd15);
        out_ready = 1'b0;

        // Asynchronous reset while FULL.
        offer(16'h7, 8'h07);
        tick();
        offer(16'h8, 8'h08);
        tick();
        in_valid = 1'b0;
        chk("ar_full", 32'(in_ready), 32'd0);
        chk("ar_bub_kept", 32'(bubble_cnt), 32'd15);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_v", 32'(out_valid), 32'd0);
        chk("ar_rdy", 32'(in_ready), 32'd1);
        chk("ar_bub", 32'(bubble_cnt), 32'd0);
        chk("ar_d", 32'(out_data), 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        offer(16'h5, 8'h55);
        tick();
        in_valid = 1'b0;
        chk("ar_after_d", 32'(out_data), 32'h5);
        chk("ar_after_v", 32'(out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
